// File: rtl/mem_port_arbiter.sv
// Two-into-one memory bus arbiter: instruction and data ports share one memory master port,
// with a routing FIFO that steers in-order responses back to the port that issued the request.
module mem_port_arbiter #(
    parameter int C_OUTSTANDING_X = 2,
    parameter bit C_DATA_PRIORITY = 1'b0
) (
    input  logic        clk_i,
    input  logic        resetb_i,
    input  logic        clk_en_i,

    output logic        ireqready_o,
    input  logic        ireqvalid_i,
    input  logic [1:0]  ireqhpl_i,
    input  logic [31:0] ireqaddr_i,
    input  logic        irspready_i,
    output logic        irspvalid_o,
    output logic        irsprerr_o,
    output logic [31:0] irspdata_o,

    output logic        dreqready_o,
    input  logic        dreqvalid_i,
    input  logic [1:0]  dreqsize_i,
    input  logic        dreqdvalid_i,
    input  logic [1:0]  dreqhpl_i,
    input  logic [31:0] dreqaddr_i,
    input  logic [31:0] dreqdata_i,
    input  logic        drspready_i,
    output logic        drspvalid_o,
    output logic        drsprerr_o,
    output logic        drspwerr_o,
    output logic [31:0] drspdata_o,

    input  logic        mreqready_i,
    output logic        mreqvalid_o,
    output logic [1:0]  mreqsize_o,
    output logic        mreqdvalid_o,
    output logic [1:0]  mreqhpl_o,
    output logic [31:0] mreqaddr_o,
    output logic [31:0] mreqdata_o,
    output logic        mrspready_o,
    input  logic        mrspvalid_i,
    input  logic        mrsprerr_i,
    input  logic        mrspwerr_i,
    input  logic [31:0] mrspdata_i
);

    // Handshake: a beat moves on a rising clk_i edge when valid & ready & clk_en_i are all 1;
    // a presented request is held stable by the requester until it is accepted.

    localparam int L_DEPTH = 1 << C_OUTSTANDING_X;
    localparam int L_PW    = C_OUTSTANDING_X + 1;
    localparam logic [L_PW-1:0] L_FULL_DIFF = {1'b1, {C_OUTSTANDING_X{1'b0}}};

    // Port IDs stored in the routing FIFO: 0 = instruction, 1 = data.
    logic [L_DEPTH-1:0] r_fifo;
    logic [L_PW-1:0]    r_wptr;
    logic [L_PW-1:0]    r_rptr;
    logic               r_lock;
    logic               r_lock_d;
    logic               r_last_d;

    logic               w_gnt_d;
    logic               w_gnt_valid;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_head_d;

    // Full/empty come from registered pointers only, so a same-cycle pop cannot admit a push.
    assign w_full   = ((r_wptr ^ r_rptr) == L_FULL_DIFF);
    assign w_empty  = (r_wptr == r_rptr);
    assign w_head_d = r_fifo[r_rptr[C_OUTSTANDING_X-1:0]];

    always_comb begin
        w_gnt_d = 1'b0;
        if (r_lock) begin
            w_gnt_d = r_lock_d;
        end else if (ireqvalid_i && dreqvalid_i) begin
            w_gnt_d = C_DATA_PRIORITY ? 1'b1 : ~r_last_d;
        end else begin
            w_gnt_d = dreqvalid_i;
        end
    end

    assign w_gnt_valid = w_gnt_d ? dreqvalid_i : ireqvalid_i;

    assign mreqvalid_o  = w_gnt_valid & ~w_full;
    assign mreqaddr_o   = w_gnt_d ? dreqaddr_i : ireqaddr_i;
    assign mreqhpl_o    = w_gnt_d ? dreqhpl_i : ireqhpl_i;
    assign mreqsize_o   = w_gnt_d ? dreqsize_i : 2'b10;
    assign mreqdvalid_o = w_gnt_d & dreqdvalid_i;
    assign mreqdata_o   = w_gnt_d ? dreqdata_i : 32'h0;

    assign ireqready_o = ~w_gnt_d & mreqready_i & ~w_full & clk_en_i;
    assign dreqready_o =  w_gnt_d & mreqready_i & ~w_full & clk_en_i;

    assign w_push = mreqvalid_o & mreqready_i & clk_en_i;

    assign irspvalid_o = ~w_empty & ~w_head_d & mrspvalid_i;
    assign drspvalid_o = ~w_empty &  w_head_d & mrspvalid_i;
    assign mrspready_o = ~w_empty & (w_head_d ? drspready_i : irspready_i) & clk_en_i;

    assign irsprerr_o = mrsprerr_i;
    assign irspdata_o = mrspdata_i;
    assign drsprerr_o = mrsprerr_i;
    assign drspwerr_o = mrspwerr_i;
    assign drspdata_o = mrspdata_i;

    assign w_pop = mrspvalid_i & mrspready_o;

    // last_grant resets to I so the data port wins the first conflict.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_fifo   <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_lock   <= 1'b0;
            r_lock_d <= 1'b0;
            r_last_d <= 1'b0;
        end else if (clk_en_i) begin
            if (w_push) begin
                r_fifo[r_wptr[C_OUTSTANDING_X-1:0]] <= w_gnt_d;
                r_wptr   <= r_wptr + L_PW'(1);
                r_last_d <= w_gnt_d;
                r_lock   <= 1'b0;
            end else if (mreqvalid_o && !mreqready_i) begin
                r_lock   <= 1'b1;
                r_lock_d <= w_gnt_d;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + L_PW'(1);
            end
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory bus between the core's instruction port and data port, for single-port memory systems.
- Sits between the core's instruction/data port pairs and one downstream memory master port.
- Arbitrates requests round-robin, or with fixed data priority when configured.
- Records the grant order in a routing FIFO so that in-order responses return to the requester that issued them.

Parameters:
C_OUTSTANDING_X, 2, base-2 exponent of the routing FIFO depth (maximum outstanding requests = 2^C_OUTSTANDING_X).
C_DATA_PRIORITY, 0, 0 = round-robin on conflict; 1 = the data port always wins on conflict.

Ports:
clk_i  in  1  clock
resetb_i  in  1  reset; asynchronous, active-low
clk_en_i  in  1  clock enable; no transfer or state update when low
ireqready_o  out  1  instruction request accepted
ireqvalid_i  in  1  instruction request valid
ireqhpl_i  in  2  instruction HART privilege level
ireqaddr_i  in  32  instruction fetch address
irspready_i  in  1  instruction requester ready for a response
irspvalid_o  out  1  instruction response valid
irsprerr_o  out  1  instruction read error
irspdata_o  out  32  instruction data
dreqready_o  out  1  data request accepted
dreqvalid_i  in  1  data request valid
dreqsize_i  in  2  data access size
dreqdvalid_i  in  1  data request is a write (write data valid)
dreqhpl_i  in  2  data HART privilege level
dreqaddr_i  in  32  data address
dreqdata_i  in  32  data write data
drspready_i  in  1  data requester ready for a response
drspvalid_o  out  1  data response valid
drsprerr_o  out  1  data read error
drspwerr_o  out  1  data write error
drspdata_o  out  32  data read data
mreqready_i  in  1  memory accepts request
mreqvalid_o  out  1  memory request valid
mreqsize_o  out  2  memory access size
mreqdvalid_o  out  1  memory request is a write
mreqhpl_o  out  2  memory privilege level
mreqaddr_o  out  32  memory address
mreqdata_o  out  32  memory write data
mrspready_o  out  1  arbiter ready for a memory response
mrspvalid_i  in  1  memory response valid
mrsprerr_i  in  1  memory read error
mrspwerr_i  in  1  memory write error
mrspdata_i  in  32  memory response data

Behaviour:
- Transfer rule: a transfer occurs on a rising clk_i edge where valid & ready & clk_en_i. When clk_en_i=0, all ready outputs are driven 0.
- Reset (resetb_i low, asynchronous):
  - routing FIFO empty; lock=0; last_grant=I, so the data port wins the first conflict.
  - outputs: mreqvalid_o=0, irspvalid_o=0, drspvalid_o=0, mrspready_o=0, ireqready_o=0, dreqready_o=0.
  - Reset mid-transaction discards all outstanding routing entries. Memory responses arriving after reset and before any new grant are not accepted, because mrspready_o=0 while the FIFO is empty.
- Grant selection (combinational, zero latency):
  - If lock=1, keep the locked grant.
  - Otherwise, if only one port is valid, grant that port.
  - If both ports are valid: with C_DATA_PRIORITY=1, grant D. With C_DATA_PRIORITY=0, grant the port not equal to last_grant.
- Request path:
  - mreqvalid_o = granted valid & ~fifo_full.
  - mreq* fields are muxed from the granted port.
  - An instruction grant forces mreqsize_o=2'b10, mreqdvalid_o=0 and mreqdata_o=0.
- Request ready: granted port ready = mreqready_i & ~fifo_full & clk_en_i. The non-granted port's ready = 0.
- Lock:
  - Set when mreqvalid_o=1, mreqready_i=0 and clk_en_i=1.
  - Cleared on the accepting transfer.
  - Guarantees request stability: a presented request is never withdrawn or switched by the arbiter.
- On an accepted request:
  - Push the port ID (0=I, 1=D) into the routing FIFO.
  - last_grant <= the granted port.
- Response path:
  - If the FIFO is non-empty, the head ID selects the target port. Target rspvalid = mrspvalid_i; target fields = mrsp* inputs; mrspready_o = target rspready & clk_en_i.
  - Non-target rspvalid = 0.
  - irspvalid_o, drspvalid_o and mrspready_o are 0 when the FIFO is empty.
  - drspwerr_o is driven from mrspwerr_i. Instruction responses ignore mrspwerr_i.
  - The FIFO head pops on a response transfer.
- FIFO:
  - Depth 2^C_OUTSTANDING_X; pointers are C_OUTSTANDING_X+1 bits and wrap naturally.
  - full = MSBs differ and lower bits equal; empty = pointers equal.
  - Simultaneous push and pop: legal when not full; the count is unchanged.
  - When full, pushes are blocked even if a pop occurs in the same cycle. The full check uses registered state only, so there is no ready→valid combinational loop through the response path.
- Ordering: responses are assumed in-order from memory. Response latency adds 0 cycles (combinational routing).

Test Plan:
- Reset, then I-only fetch at 0x100 with mreqready_i=1 → mreqaddr_o=0x100, mreqsize_o=2'b10, mreqdvalid_o=0 in the same cycle. Memory response data 0x00000013 → irspvalid_o=1, irspdata_o=0x00000013, drspvalid_o=0.
- I and D (store, addr 0x2000, data 0xDEADBEEF, size 2'b10) both valid every cycle, C_DATA_PRIORITY=0 → grants alternate D, I, D, I starting with D. Responses route in the same order.
- C_DATA_PRIORITY=1, both valid for 4 cycles → 4 consecutive D grants; ireqready_o stays 0.
- mreqready_i=0 for 3 cycles with I presented, then D becomes valid → mreq* fields stay stable on the I request. I is accepted on the first cycle mreqready_i=1; D is granted next.
- Issue 4 requests with no responses (C_OUTSTANDING_X=2) → 5th request: mreqvalid_o=0 and ready=0. A response transfer in the same cycle still does not admit the request; it is accepted on the following cycle.
- Assert resetb_i with 2 outstanding requests and mrspvalid_i held 1 → mrspready_o=0, irspvalid_o=0, drspvalid_o=0 immediately and after release until a new grant.
